// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment type, blank pattern and hex glyph table for the scan driver
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} glyphs, indexed by nibble value
  localparam seg_t SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_seg_lut.sv
// rtl/hex_seg_lut.sv - combinational nibble to active-low seven-segment decoder
module hex_seg_lut
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - multiplexed seven-segment scanner with frame-synchronous update
// Leading-zero blanking is compiled in only when SEVENSEG_LZ_BLANK_EN is defined.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  typedef logic [NUM_DIGITS-1:0][3:0] nib_arr_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  nib_arr_t              pend_val_q, pend_val_d;
  nib_arr_t              act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick, frame_end, digit_blank;
  seg_t                  lut_seg;

  assign tick      = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx_q == IW'(NUM_DIGITS - 1));

  // Active only moves at the frame boundary, so it sees pending as it was before any coincident load
  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (tick) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    act_val_d  = frame_end ? pend_val_q : act_val_q;
    act_dp_d   = frame_end ? pend_dp_q : act_dp_q;
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (act_val_q[i] != 4'h0) msd = IW'(i);
    end
  end

  assign digit_blank = blank_lz && (idx_q > msd);
`else
  logic unused_blank_lz;
  assign unused_blank_lz = blank_lz;
  assign digit_blank     = 1'b0;
`endif

  hex_seg_lut u_lut (
    .nibble (act_val_q[idx_q]),
    .seg    (lut_seg)
  );

  // Dark window at the start of each slot hides the anode/segment switch-over
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (presc_q >= PW'(BLANK_CYCLES)) begin
      an_d[idx_q] = 1'b0;
      if (!digit_blank) begin
        seg_d = lut_seg;
        dp_d  = ~act_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb/tb_sevenseg_scan_driver.sv - scoreboard bench for the seven-segment scan driver
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t sb[$];

`ifdef SEVENSEG_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  sevenseg_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg_o),
    .dp       (dp_o),
    .an       (an_o)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpi, input bit lzb);
    int    top;
    slot_t s;
    bit    blank;
    top = 0;
    for (int d = 1; d < 4; d++) if (v[4*d +: 4] != 4'h0) top = d;
    for (int d = 0; d < 4; d++) begin
      blank    = lzb && (d > top);
      s.an     = 4'hF;
      s.an[d]  = 1'b0;
      s.seg    = blank ? 7'h7F : glyph(v[4*d +: 4]);
      s.dp     = blank ? 1'b1 : ~dpi[d];
      sb.push_back(s);
    end
  endtask

  // Returns at the first lit sample of the wanted anode that directly follows a dark sample
  task automatic wait_lit(input logic [3:0] want, output bit ok);
    logic [3:0] prev;
    prev = an_o;
    ok   = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (an_o === want && prev === 4'hF) ok = 1'b1;
      else prev = an_o;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpi);
    value = v;
    dp_in = dpi;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold an/seg/dp=%b/%b/%b required 1111/1111111/1", an_o, seg_o, dp_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_dark an/seg/dp=%b/%b/%b required 1111/1111111/1", an_o, seg_o, dp_o);
    end
    @(negedge clk);
    checks++;
    if ({an_o, seg_o, dp_o} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_slot an/seg/dp=%b/%b/%b required 1110/1000000/1", an_o, seg_o, dp_o);
    end
  endtask

  task automatic test_scan;
    bit ok;
    wait_lit(4'b1101, ok);
    do_load(16'h12AF, 4'b0100);
    push_frame(16'h12AF, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      slot_t e;
      e = sb.pop_front();
      wait_lit(e.an, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL scan_find%0d an=%b required %b", k, an_o, e.an); end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({an_o, seg_o, dp_o} !== e) begin
          errors++;
          $display("FAIL scan_lit%0d_%0d got %b required %b", k, c, {an_o, seg_o, dp_o}, e);
        end
        @(negedge clk);
      end
      checks++;
      if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL scan_dark%0d got %b required 111111111111", k, {an_o, seg_o, dp_o});
      end
    end
  endtask

  task automatic test_tearing;
    bit ok;
    wait_lit(4'b1101, ok);
    do_load(16'h1111, 4'b0000);
    push_frame(16'h1111, 4'b0000, 1'b0);
    push_frame(16'h2222, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      slot_t e;
      e = sb.pop_front();
      wait_lit(e.an, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL tear_find%0d an=%b required %b", k, an_o, e.an); end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({an_o, seg_o, dp_o} !== e) begin
          errors++;
          $display("FAIL tear_lit%0d_%0d got %b required %b", k, c, {an_o, seg_o, dp_o}, e);
        end
        if (c == 0 && (k == 1 || k == 2)) begin
          value = (k == 1) ? 16'h3333 : 16'h2222;
          load  = 1'b1;
        end else begin
          load  = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_coincident;
    bit ok;
    wait_lit(4'b1101, ok);
    do_load(16'h9999, 4'b0001);
    wait_lit(4'b0111, ok);
    @(negedge clk);
    do_load(16'h0005, 4'b0000);
    push_frame(16'h9999, 4'b0001, 1'b0);
    push_frame(16'h0005, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      slot_t e;
      e = sb.pop_front();
      wait_lit(e.an, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL coinc_find%0d an=%b required %b", k, an_o, e.an); end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({an_o, seg_o, dp_o} !== e) begin
          errors++;
          $display("FAIL coinc_lit%0d_%0d got %b required %b", k, c, {an_o, seg_o, dp_o}, e);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_blank;
    bit ok;
    blank_lz = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      wait_lit(4'b1101, ok);
      do_load(ph == 0 ? 16'h0050 : 16'h0000, ph == 0 ? 4'b1000 : 4'b0001);
      push_frame(ph == 0 ? 16'h0050 : 16'h0000, ph == 0 ? 4'b1000 : 4'b0001, LZ_ON);
      for (int k = 0; k < 4; k++) begin
        slot_t e;
        e = sb.pop_front();
        wait_lit(e.an, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blank_find%0d_%0d an=%b required %b", ph, k, an_o, e.an); end
        for (int c = 0; c < 3; c++) begin
          checks++;
          if ({an_o, seg_o, dp_o} !== e) begin
            errors++;
            $display("FAIL blank_lit%0d_%0d_%0d got %b required %b", ph, k, c, {an_o, seg_o, dp_o}, e);
          end
          @(negedge clk);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_mid_reset;
    bit ok;
    wait_lit(4'b1101, ok);
    do_load(16'h7777, 4'b1111);
    wait_lit(4'b1011, ok);
    rst = 1'b1;
    #1;
    checks++;
    if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL midrst_dark got %b required 111111111111", {an_o, seg_o, dp_o});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an_o !== 4'hF) begin errors++; $display("FAIL midrst_blank an=%b required 1111", an_o); end
    @(negedge clk);
    checks++;
    if ({an_o, seg_o, dp_o} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("FAIL midrst_first got %b required 111010000001", {an_o, seg_o, dp_o});
    end
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      slot_t e;
      e = sb.pop_front();
      wait_lit(e.an, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_find%0d an=%b required %b", k, an_o, e.an); end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({an_o, seg_o, dp_o} !== e) begin
          errors++;
          $display("FAIL midrst_lit%0d_%0d got %b required %b", k, c, {an_o, seg_o, dp_o}, e);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_coincident();
    test_blank();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
